booth_dot_accumulator: RTL and testbench

//  Downstream stage of the BoothRadix4 multiplier. Consumes its signed 32-bit

---
 rtl/booth_dot_accumulator_pkg.sv | 9 +
 rtl/booth_dot_accumulator_sat_add.sv | 17 +
 rtl/booth_dot_accumulator.sv | 65 ++++++
 tb/tb_booth_dot_accumulator.sv | 129 ++++++++++++
 4 files changed

// File: rtl/booth_dot_accumulator_pkg.sv
// booth_dot_accumulator_pkg: shared widths, FSM encodings and saturation bounds
package booth_dot_accumulator_pkg;
  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};
endpackage

// File: rtl/booth_dot_accumulator_sat_add.sv
// sat_add: combinational signed adder that clamps to the representable range
module sat_add
  import booth_dot_accumulator_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] full;
  assign full = {a[W-1], a} + {b[W-1], b};
  // top two bits disagree exactly when the W-bit result would wrap
  assign ovf = full[W] ^ full[W-1];
  assign sum = ovf ? {full[W], {(W-1){~full[W]}}} : full[W-1:0];
endmodule

// File: rtl/booth_dot_accumulator.sv
// booth_dot_accumulator: accumulates a run of signed products into one saturating dot-product result
module booth_dot_accumulator
  import booth_dot_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  output logic              dot_valid,
  input  logic              dot_ready,
  output logic [ACC_W-1:0]  dot_out,
  output logic [CNT_W-1:0]  dot_count,
  output logic              dot_ovf
);
  state_t state, state_n;
  logic started, accept, ovf, add_ovf, ovf_n;
  logic [ACC_W-1:0] acc, ext, sum, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign ext = ACC_W'($signed(prod));
  assign accept = prod_valid & prod_ready;
  sat_add #(.W(ACC_W)) u_add (.a(acc), .b(ext), .sum(sum), .ovf(add_ovf));
  assign acc_n = (state == IDLE) ? ext : sum;
  assign cnt_n = (state == IDLE) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
  assign ovf_n = (state != IDLE) & (ovf | add_ovf);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == HOLD) ? (dot_ready ? IDLE : HOLD)
            : accept ? (prod_last ? HOLD : ACCUM) : state;
  end
  // ready stays low until the first edge after reset releases
  always_comb begin
    prod_ready = started & (state != HOLD);
    dot_valid  = (state == HOLD);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      started   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      dot_out   <= '0;
      dot_count <= '0;
      dot_ovf   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        acc <= acc_n;
        cnt <= cnt_n;
        ovf <= ovf_n;
      end
      if (accept & prod_last) begin
        dot_out   <= acc_n;
        dot_count <= cnt_n;
        dot_ovf   <= ovf_n;
      end
    end
endmodule

// File: tb/tb_booth_dot_accumulator.sv
// tb_booth_dot_accumulator: directed scoreboard bench for the dot-product accumulator
module tb_booth_dot_accumulator;
  typedef struct {
    logic [39:0] out;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic prod_valid = 1'b0, prod_last = 1'b0, dot_ready = 1'b1;
  logic [31:0] prod = '0;
  logic prod_ready, dot_valid, dot_ovf;
  logic [39:0] dot_out;
  logic [7:0] dot_count;
  int pass_cnt = 0, total = 0;
  exp_t q[$];
  longint m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 0, m_first = 1;
  localparam longint MAXV = (64'sd1 <<< 39) - 1;
  localparam longint MINV = -(64'sd1 <<< 39);
  booth_dot_accumulator dut (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod(prod), .prod_last(prod_last), .dot_valid(dot_valid), .dot_ready(dot_ready),
    .dot_out(dot_out), .dot_count(dot_count), .dot_ovf(dot_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  always @(negedge clk)
    if (!reset && dot_valid && dot_ready) begin
      if (q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dot_out", {24'd0, dot_out}, {24'd0, e.out});
        chk("dot_count", {56'd0, dot_count}, {56'd0, e.cnt});
        chk("dot_ovf", {63'd0, dot_ovf}, {63'd0, e.ovf});
      end
    end
  task automatic send(input logic [31:0] p, input logic l);
    bit ok = 0;
    longint sp;
    prod_valid = 1'b1; prod = p; prod_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = prod_ready;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    sp = longint'($signed(p));
    if (m_first) begin m_acc = sp; m_cnt = 1; m_ovf = 0; end
    else begin
      m_acc = m_acc + sp;
      if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1; end
      else if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1; end
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end
    m_first = l;
    if (l) q.push_back('{out: m_acc[39:0], cnt: 8'(m_cnt), ovf: m_ovf});
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1 chk("drain", 64'(q.size()), 64'd0);
  endtask
  initial begin
    #12 reset = 1'b0;
    #1;
    chk("rst_ready_low", {63'd0, prod_ready}, 64'd0);
    chk("rst_valid", {63'd0, dot_valid}, 64'd0);
    chk("rst_out", {24'd0, dot_out}, 64'd0);
    chk("rst_count", {56'd0, dot_count}, 64'd0);
    @(posedge clk); #1;
    chk("ready_after_rst", {63'd0, prod_ready}, 64'd1);
    send(32'd12, 1'b1);
    chk("t1_latency", {63'd0, dot_valid}, 64'd1);
    chk("t1_ready_hold", {63'd0, prod_ready}, 64'd0);
    drain();
    chk("t1_ready_back", {63'd0, prod_ready}, 64'd1);
    send(32'd12, 1'b0);
    send(-32'sd5, 1'b0);
    send(32'd100, 1'b1);
    drain();
    chk("t2_idle", {63'd0, dot_valid}, 64'd0);
    chk("t2_ready", {63'd0, prod_ready}, 64'd1);
    chk("t2_out_held", {24'd0, dot_out}, 64'd107);
    dot_ready = 1'b0;
    send(32'd5, 1'b1);
    prod_valid = 1'b1; prod = 32'd9; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_ready_low", {63'd0, prod_ready}, 64'd0);
      chk("t3_valid_held", {63'd0, dot_valid}, 64'd1);
      chk("t3_out_stable", {24'd0, dot_out}, 64'd5);
    end
    @(posedge clk); #1;
    dot_ready = 1'b1;
    send(32'd9, 1'b1);
    drain();
    for (int i = 0; i < 300; i++) send(32'h7FFF_FFFF, i == 299);
    drain();
    for (int i = 0; i < 300; i++) send(32'h8000_0000, i == 299);
    drain();
    for (int i = 0; i < 4; i++) begin
      send(32'd1, i == 3);
      @(posedge clk); #1;
    end
    drain();
    chk("t5_out_held", {24'd0, dot_out}, 64'd4);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    #2 reset = 1'b1;
    m_first = 1;
    #1;
    chk("t6_out_zero", {24'd0, dot_out}, 64'd0);
    chk("t6_count_zero", {56'd0, dot_count}, 64'd0);
    chk("t6_ready_zero", {63'd0, prod_ready}, 64'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("t6_ready_pre_edge", {63'd0, prod_ready}, 64'd0);
    send(32'd7, 1'b1);
    drain();
    chk("t6_valid_idle", {63'd0, dot_valid}, 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
